// File: rtl/ext_bus_pkg.sv
// Shared types and helpers for the pin-multiplexed external bus sequencer.
package ext_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_TURN,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_ADDR = 2'b01;
  localparam logic [1:0] PH_DATA = 2'b10;
  localparam logic [1:0] PH_TURN = 2'b11;

  // Number of PIN_W-wide beats needed to carry a field of width a.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/ext_bus_shifter.sv
// Load / shift-out / shift-in register of N beats; the MSB beat is presented on the pins.
module ext_bus_shifter #(
  parameter int N     = 1,
  parameter int PIN_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [N*PIN_W-1:0] load_val,
  input  logic               shift,
  input  logic [PIN_W-1:0]   shift_in,
  output logic [PIN_W-1:0]   beat,
  output logic [N*PIN_W-1:0] shifted
);

  localparam int W = N * PIN_W;

  logic [W-1:0] value;

  // A single-beat register has no remaining bits to move up; the new beat replaces it.
  if (N == 1) begin : g_single
    assign shifted = shift_in;
  end else begin : g_multi
    assign shifted = {value[W-PIN_W-1:0], shift_in};
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     value <= '0;
    else if (load)  value <= load_val;
    else if (shift) value <= shifted;
  end

  assign beat = value[W-1 -: PIN_W];

endmodule

// File: rtl/ext_bus_sequencer.sv
// External memory bus master: serialises CPU requests into address/turnaround/data beats
// on a narrow bidirectional pin group, with wait-states and timeout abort.
module ext_bus_sequencer
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 4,
  parameter int PIN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [PIN_W-1:0]  bus_out,
  output logic [PIN_W-1:0]  bus_oe,
  input  logic [PIN_W-1:0]  bus_in,
  output logic              bus_rw,
  output logic [1:0]        bus_phase,
  input  logic              bus_rdy
);

  localparam int AB     = ceil_div(ADDR_W, PIN_W);
  localparam int DB     = ceil_div(DATA_W, PIN_W);
  localparam int AW     = AB * PIN_W;
  localparam int DW     = DB * PIN_W;
  localparam int MAXB   = (AB > DB) ? AB : DB;
  localparam int CNT_W  = $clog2(MAXB + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  AB_LAST   = CNT_W'(AB - 1);
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DB - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                we_q;
  logic                err_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic                accept, addr_shift, addr_last;
  logic                beat_done, beat_wait, abort, read_done;
  logic [PIN_W-1:0]    addr_beat, data_beat;
  logic [AW-1:0]       addr_shifted;
  logic [DW-1:0]       data_shifted;
  logic                unused_shift_bits;

  ext_bus_shifter #(.N(AB), .PIN_W(PIN_W)) u_addr_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (AW'(req_addr)),
    .shift    (addr_shift),
    .shift_in ('0),
    .beat     (addr_beat),
    .shifted  (addr_shifted)
  );

  // Shared between directions: write data shifts out, read data shifts in from the pins.
  ext_bus_shifter #(.N(DB), .PIN_W(PIN_W)) u_data_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (DW'(req_wdata)),
    .shift    (beat_done),
    .shift_in (bus_in),
    .beat     (data_beat),
    .shifted  (data_shifted)
  );

  assign unused_shift_bits = ^{addr_shifted, data_shifted};
  assign addr_last         = (beat_cnt_q == AB_LAST);

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    addr_shift = 1'b0;
    beat_done  = 1'b0;
    beat_wait  = 1'b0;
    abort      = 1'b0;
    read_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        addr_shift = 1'b1;
        if (addr_last) state_d = we_q ? ST_DATA : ST_TURN;
      end
      ST_TURN: state_d = ST_DATA;
      ST_DATA: begin
        if (bus_rdy) begin
          beat_done = 1'b1;
          if (beat_cnt_q == DB_LAST) begin
            read_done = !we_q;
            state_d   = ST_DONE;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          abort   = 1'b1;
          state_d = ST_DONE;
        end else begin
          beat_wait = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      beat_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q       <= req_we;
        err_q      <= 1'b0;
        beat_cnt_q <= '0;
        wait_cnt_q <= '0;
      end
      // The beat counter is reused: it returns to zero at the end of the address phase.
      if (addr_shift) beat_cnt_q <= addr_last ? '0 : beat_cnt_q + CNT_W'(1);
      if (beat_done) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        wait_cnt_q <= '0;
      end else if (beat_wait) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
      if (abort)     err_q       <= 1'b1;
      if (read_done) rsp_rdata_q <= data_shifted[DATA_W-1:0];
    end
  end

  always_comb begin
    bus_phase = PH_IDLE;
    unique case (state_q)
      ST_ADDR: bus_phase = PH_ADDR;
      ST_TURN: bus_phase = PH_TURN;
      ST_DATA: bus_phase = PH_DATA;
      default: bus_phase = PH_IDLE;
    endcase
  end

  logic drive;
  assign drive     = (state_q == ST_ADDR) || ((state_q == ST_DATA) && we_q);
  assign bus_oe    = {PIN_W{drive}};
  assign bus_out   = (state_q == ST_ADDR) ? addr_beat :
                     ((state_q == ST_DATA) && we_q) ? data_beat : '0;
  assign bus_rw    = we_q && (state_q inside {ST_ADDR, ST_TURN, ST_DATA});
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_err   = (state_q == ST_DONE) && err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Self-checking bench: default 11/4/4 instance plus a 16/8/4 instance, driven by directed and random transactions.
module tb_ext_bus_sequencer;

  localparam int PIN_W   = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel;
  logic        req_valid, req_we, bus_rdy;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [3:0]  bus_in;

  logic       r0_ready, r0_valid, r0_err, b0_rw;
  logic [3:0] r0_rdata, b0_out, b0_oe;
  logic [1:0] b0_phase;
  logic       r1_ready, r1_valid, r1_err, b1_rw;
  logic [7:0] r1_rdata;
  logic [3:0] b1_out, b1_oe;
  logic [1:0] b1_phase;

  ext_bus_sequencer u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_ready(r0_ready), .req_we(req_we),
    .req_addr(req_addr[10:0]), .req_wdata(req_wdata[3:0]),
    .rsp_valid(r0_valid), .rsp_rdata(r0_rdata), .rsp_err(r0_err),
    .bus_out(b0_out), .bus_oe(b0_oe), .bus_in(bus_in), .bus_rw(b0_rw),
    .bus_phase(b0_phase), .bus_rdy(bus_rdy)
  );

  ext_bus_sequencer #(.ADDR_W(16), .DATA_W(8), .PIN_W(4), .TIMEOUT(TIMEOUT)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_ready(r1_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r1_valid), .rsp_rdata(r1_rdata), .rsp_err(r1_err),
    .bus_out(b1_out), .bus_oe(b1_oe), .bus_in(bus_in), .bus_rw(b1_rw),
    .bus_phase(b1_phase), .bus_rdy(bus_rdy)
  );

  logic       o_ready, o_valid, o_err, o_rw;
  logic [7:0] o_rdata;
  logic [3:0] o_out, o_oe;
  logic [1:0] o_phase;
  assign o_ready = sel ? r1_ready : r0_ready;
  assign o_valid = sel ? r1_valid : r0_valid;
  assign o_err   = sel ? r1_err   : r0_err;
  assign o_rw    = sel ? b1_rw    : b0_rw;
  assign o_rdata = sel ? r1_rdata : {4'h0, r0_rdata};
  assign o_out   = sel ? b1_out   : b0_out;
  assign o_oe    = sel ? b1_oe    : b0_oe;
  assign o_phase = sel ? b1_phase : b0_phase;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] rdata_model [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int addr_w();
    return sel ? 16 : 11;
  endfunction

  function automatic int data_w();
    return sel ? 8 : 4;
  endfunction

  // Beat k (MSB first) of a value split into nbeats PIN_W-bit pieces.
  function automatic logic [3:0] beat_of(input int unsigned v, input int nbeats, input int k);
    return 4'((v >> ((nbeats - 1 - k) * PIN_W)) & 32'hF);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".ready"}, o_ready, 1);
    check({tag, ".valid"}, o_valid, 0);
    check({tag, ".err"},   o_err,   0);
    check({tag, ".phase"}, o_phase, 0);
    check({tag, ".oe"},    o_oe,    0);
    check({tag, ".out"},   o_out,   0);
    check({tag, ".rw"},    o_rw,    0);
    check({tag, ".rdata"}, o_rdata, rdata_model[sel]);
  endtask

  // One complete transaction. waitN = low-ready cycles before data beat N; >= TIMEOUT means never ready.
  task automatic run_txn(input string tag, input logic we, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rsrc,
                         input int wait0, input int wait1);
    int ab, db, w;
    bit aborted;
    int unsigned a_z, d_z;
    ab = (addr_w() + PIN_W - 1) / PIN_W;
    db = (data_w() + PIN_W - 1) / PIN_W;
    a_z = 32'(addr) & ((32'd1 << addr_w()) - 1);
    d_z = 32'(wdata) & ((32'd1 << data_w()) - 1);
    aborted = 1'b0;

    @(negedge clk);
    check({tag, ".accept_ready"}, o_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    bus_rdy = 1'($urandom); bus_in = 4'($urandom);
    @(posedge clk);

    for (int k = 0; k < ab; k++) begin
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
      bus_rdy = 1'($urandom); bus_in = 4'($urandom);
      check({tag, ".a_phase"}, o_phase, 2'b01);
      check({tag, ".a_oe"},    o_oe,    4'hF);
      check({tag, ".a_rw"},    o_rw,    we);
      check({tag, ".a_out"},   o_out,   beat_of(a_z, ab, k));
      check({tag, ".a_busy"},  {o_ready, o_valid}, 2'b00);
    end

    if (!we) begin
      @(negedge clk);
      check({tag, ".t_phase"}, o_phase, 2'b11);
      check({tag, ".t_oe"},    o_oe,    4'h0);
      check({tag, ".t_out"},   o_out,   4'h0);
      check({tag, ".t_busy"},  {o_ready, o_valid}, 2'b00);
    end

    for (int j = 0; j < db && !aborted; j++) begin
      w = (j == 0) ? wait0 : wait1;
      for (int c = 0; c <= TIMEOUT; c++) begin
        @(negedge clk);
        check({tag, ".d_phase"}, o_phase, 2'b10);
        check({tag, ".d_oe"},    o_oe,    we ? 4'hF : 4'h0);
        check({tag, ".d_out"},   o_out,   we ? beat_of(d_z, db, j) : 4'h0);
        check({tag, ".d_rw"},    o_rw,    we);
        check({tag, ".d_busy"},  {o_ready, o_valid}, 2'b00);
        bus_rdy = (c >= w);
        bus_in  = bus_rdy ? beat_of(32'(rsrc), db, j) : 4'($urandom);
        if (!bus_rdy && c == TIMEOUT - 1) aborted = 1'b1;
        if (bus_rdy || aborted) break;
      end
    end

    if (!we && !aborted) rdata_model[sel] = 8'(32'(rsrc) & ((32'd1 << data_w()) - 1));

    @(negedge clk);
    bus_rdy = 1'($urandom); bus_in = 4'($urandom);
    check({tag, ".rsp_valid"}, o_valid, 1);
    check({tag, ".rsp_err"},   o_err,   aborted);
    check({tag, ".rsp_rdata"}, o_rdata, rdata_model[sel]);
    check({tag, ".done_ph"},   {o_phase, o_oe}, 6'h00);
    check({tag, ".done_rdy"},  o_ready, 0);
  endtask

  task automatic random_txns(input string tag, input int n);
    int w0, w1;
    for (int i = 0; i < n; i++) begin
      w0 = ($urandom_range(0, 7) == 0) ? TIMEOUT + 3 : $urandom_range(0, 3);
      w1 = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 3);
      run_txn(tag, 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), w0, w1);
    end
  endtask

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    bus_in = '0; bus_rdy = 1'b0;
    rdata_model[0] = '0; rdata_model[1] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset0");

    run_txn("t1_write", 1'b1, 16'h05A3, 8'h09, 8'h00, 0, 0);
    run_txn("t2_read",  1'b0, 16'h0001, 8'h00, 8'h0C, 0, 0);
    run_txn("t3_wait",  1'b0, 16'h0234, 8'h00, 8'h07, 3, 0);
    run_txn("t4_tmo",   1'b0, 16'h07FF, 8'h00, 8'h05, TIMEOUT, 0);
    run_txn("t4_next",  1'b1, 16'h0412, 8'h0E, 8'h00, 1, 0);
    run_txn("t_read2",  1'b0, 16'h0100, 8'h00, 8'h0A, 14, 0);

    // Reset pulsed during the second address beat.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0357;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("t5_beat2", o_out, 4'h5);
    #2 rst_n = 1'b0;
    #1;
    rdata_model[0] = '0; rdata_model[1] = '0;
    check_idle("t5_async");
    repeat (2) begin
      @(negedge clk);
      check("t5_hold_valid", o_valid, 0);
    end
    rst_n = 1'b1;
    check_idle("t5_release");
    run_txn("t5_fresh", 1'b0, 16'h0600, 8'h00, 8'h03, 0, 0);

    random_txns("rnd0", 20);

    @(negedge clk);
    sel = 1'b1;
    #1;
    check_idle("sel1_idle");
    run_txn("t6_write", 1'b1, 16'hBEEF, 8'hA5, 8'h00, 0, 0);
    run_txn("t6_read",  1'b0, 16'h1234, 8'h00, 8'h3C, 0, 0);
    run_txn("t6_wait",  1'b0, 16'hF00D, 8'h00, 8'h96, 1, 2);
    run_txn("t6_tmo2",  1'b0, 16'h0042, 8'h00, 8'h11, 0, TIMEOUT);
    random_txns("rnd1", 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ext_bus_sequencer.md
Name: ext_bus_sequencer

Overview:
- Parametrised pin-multiplexed external memory bus master between the CPU's parallel request port and the top-level pin set.
- Serialises address and data over a narrow PIN_W-bit bidirectional pin group, in beats.
- Supports read/write, a turnaround cycle, external wait-states and timeout abort, none of which the current fixed 4-bit/11-bit wiring provides.

Parameters:
ADDR_W, 11, CPU address width
DATA_W, 4, CPU data width
PIN_W, 4, external bidirectional data pins per beat
TIMEOUT, 15, max consecutive bus_rdy-low cycles per data beat before abort (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  sequencer can accept request (IDLE only)
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read data, held until next read completes
rsp_err  out  1  qualifies rsp_valid; 1=timeout abort
bus_out  out  PIN_W  pin output value
bus_oe  out  PIN_W  pin output enable, all-ones or all-zeros
bus_in  in  PIN_W  pin input value
bus_rw  out  1  1=write cycle in progress
bus_phase  out  2  00 idle, 01 address, 10 data, 11 turnaround
bus_rdy  in  1  external ready for current data beat

Behaviour:
- Derived: AB = ceil(ADDR_W/PIN_W), DB = ceil(DATA_W/PIN_W). Address/data zero-extended to AB*PIN_W / DB*PIN_W, sent MSB beat first.
- Reset (async assert, sync release): state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; bus_out=0; bus_oe=0; bus_rw=0; bus_phase=00; all counters 0.
- All outputs registered or pure decode of registered state; no combinational path from bus_in/bus_rdy to outputs.
- IDLE: req_ready=1. On req_valid&req_ready, latch we/addr/wdata; next state ADDR.
- ADDR: bus_phase=01, bus_oe=all-ones, bus_rw=latched we, bus_out=address beat k (k=0..AB-1). One beat per cycle; bus_rdy ignored.
  - After the last beat: write -> DATA; read -> TURN.
- TURN (read only): one cycle, bus_phase=11, bus_oe=0, bus_out=0. Then DATA.
- DATA: bus_phase=10.
  - Write: bus_oe=all-ones, bus_out=data beat j.
  - Read: bus_oe=0; bus_in is shifted into the assembly register on any edge where bus_rdy=1.
  - A beat completes on an edge where bus_rdy=1; j increments, wait counter clears.
  - If bus_rdy=0, the wait counter increments. When it reaches TIMEOUT with bus_rdy still 0, abort to DONE with err=1.
  - After beat DB-1 completes -> DONE with err=0.
- DONE: rsp_valid=1 for exactly one cycle, rsp_err=err, bus_oe=0, bus_phase=00, req_ready=0. Next state IDLE.
  - rsp_rdata updates on a successful read only; it is unchanged after a write or an aborted read.
- Throughput: a new request is accepted in IDLE the cycle after DONE. Minimum latency from accept to rsp_valid:
  - write: AB+DB+1 cycles
  - read: AB+1+DB+1 cycles
- req_valid while not IDLE is ignored; the CPU holds the request until req_ready.
- Reset mid-transaction: immediate return to reset values; no rsp_valid is issued.
- Truncation: if DATA_W is not a multiple of PIN_W, read data takes the low DATA_W bits of the assembled value.

Decomposition:
- Shared package ext_bus_pkg holds:
  - state enum (IDLE, ADDR, TURN, DATA, DONE)
  - bus_phase encodings
  - beat-count function ceil_div(a,b)
- One natural sub-module: ext_bus_shifter, a parametrised load/shift-out/shift-in register of width N*PIN_W, instantiated once for the address and once for the data.
- FSM and counters stay in the top module.

Test Plan:
1. Defaults, write addr=0x5A3 data=0x9, bus_rdy=1 -> bus_out beats 0x5,0xA,0x3 (phase 01, oe=F, rw=1), then 0x9 (phase 10), rsp_valid on cycle 5 after accept, rsp_err=0.
2. Read addr=0x001, bus_in=0xC, bus_rdy=1 -> address beats 0x0,0x0,0x1, one turnaround cycle (oe=0, phase 11), then rsp_rdata=0xC, rsp_valid on cycle 6.
3. Read with bus_rdy held low 3 cycles then high, bus_in=0x7 -> DATA phase lasts 4 cycles, rsp_rdata=0x7, rsp_err=0.
4. Read with bus_rdy low forever, TIMEOUT=15 -> rsp_valid with rsp_err=1 after 15 wait cycles; rsp_rdata keeps its previous value; next request accepted.
5. rst_n pulsed low during the second address beat -> all outputs go to reset values asynchronously; no rsp_valid; a fresh request completes normally.
6. ADDR_W=16, DATA_W=8, PIN_W=4, write 0xBEEF/0xA5 -> beats B,E,E,F then A,5; read returning nibbles 3,C -> rsp_rdata=0x3C.
